ps2_tx: RTL and testbench
=========================

# ps2_tx

Host-to-device PS/2 transmitter: the send-side companion to the keyboard receiver inside `memory`. It sends one command byte to the device, for example 0xED (set LEDs) or 0xFF (reset). It runs the full host request-to-send sequence and shifts out data, odd parity and stop. It then checks the device ACK and reports done or error. It drives the shared `P2_3`/`P2_1` lines through open-drain pull-low enables; the tristate buffers stay in the top level.

## Interface
- `CLK_HZ`, 25_000_000: frequency of `clk`; documentation only, no logic depends on it.
- `INHIBIT_CYCLES`, 2500: cycles to hold PS/2 clock low before the request (100 µs at 25 MHz).
- `TIMEOUT_CYCLES`, 375_000: maximum cycles from clock release to ACK before an error is raised (15 ms).
- `clk` in 1: system clock (`clk_out` domain).
- `reset` in 1: asynchronous, active-high; releases both lines immediately.
- `start` in 1: one-cycle request; ignored while `busy`.
- `data` in 8: byte to send; captured on the accepted `start` cycle.
- `ps2_clk_in` in 1: raw PS/2 clock pin value (asynchronous).
- `ps2_data_in` in 1: raw PS/2 data pin value (asynchronous).
- `ps2_clk_oe` out 1: 1 = pull PS/2 clock low.
- `ps2_data_oe` out 1: 1 = pull PS/2 data low.
- `busy` out 1: high from the accepted `start` until the cycle after `done`/`error`; the receiver must ignore the bus while high.
- `done` out 1: one-cycle pulse; transfer ACKed and bus idle.
- `error` out 1: one-cycle pulse; timeout or missing ACK.

## Operation
- Inputs pass through a 2-FF synchronizer; a falling edge is flagged when the synced value is 1 on the previous cycle and 0 on the current one.
- Frame: `{stop=1, parity, data[7:0]}`; parity = ~^data (odd); `data` is sent LSB first.
- `IDLE`: both oe = 0. An accepted `start` latches the frame, clears the counters and moves to `INHIBIT`.
- `INHIBIT`: `ps2_clk_oe`=1 for exactly INHIBIT_CYCLES cycles, then `REQUEST`.
- `REQUEST`: one cycle with both oe = 1, which places the start bit; then `SHIFT`.
- `SHIFT`: `ps2_clk_oe`=0 and `ps2_data_oe`=~current bit. On each synced falling edge, advance `bit_idx` 0..9:
  - edges 1–8 present data[0..7];
  - edge 9 presents parity;
  - edge 10 presents stop (data released);
  - edge 11 moves to `ACK`.
- `ACK`: data is released. Sample synced data in the same cycle as edge 11 is detected.
  - 0 → `WAIT_IDLE`.
  - 1 → `error`, `IDLE`.
- `WAIT_IDLE`: wait until synced clock and data are both 1, then pulse `done` and go to `IDLE`.
- Timeout counter: cleared on entry to `SHIFT` and counts in `SHIFT`, `ACK` and `WAIT_IDLE`. Reaching TIMEOUT_CYCLES releases both lines, pulses `error` and returns to `IDLE`.
- `start` asserted in the same cycle as `done` or `error` is ignored.

## Timing
- Reset values:
  - state `IDLE`;
  - `ps2_clk_oe`, `ps2_data_oe`, `busy`, `done`, `error` all 0;
  - synchronizer flops 1.
- `busy` rises the cycle after the accepted `start`, together with `ps2_clk_oe`.
- Clock low time is INHIBIT_CYCLES+1 cycles, which includes `REQUEST`.
- Input-to-action latency is 3 cycles: 2 synchronizer stages plus 1 edge register. This is negligible against the ≥30 µs PS/2 half-period.
- `done` and `error` are mutually exclusive; exactly one pulses per accepted `start`.
- Reset mid-transfer: both lines release asynchronously, and the device's own timeout recovers it.
- All outputs are registered.

## Structure
- Shared package `ps2_pkg`: state encoding, `PS2_FRAME_BITS`=11, odd-parity function; reused by the receiver.
- Sub-module `ps2_sync`: 2-FF synchronizer plus falling-edge detector for clock and data. The receiver instantiates the same module.
- The top level combines the pull-lows as `P2_3 = ps2_clk_oe ? 0 : z`, and likewise `P2_1` from `ps2_data_oe`.

## Test plan
All scenarios use INHIBIT_CYCLES=50 and TIMEOUT_CYCLES=5000, with a device BFM clocking at 40-cycle half-periods and sampling data on rising edges.

- Send 0xED → BFM sees start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. BFM ACKs → one `done`, no `error`, `busy` low afterwards.
- Send 0x01 → parity 0. Send 0xFF → parity 1. Send 0x00 → parity 1, and `ps2_data_oe` is high for all 8 data bits.
- BFM never clocks → `error` exactly 5000 cycles after `SHIFT` entry, both oe = 0 the next cycle.
- BFM omits the ACK (data high at edge 11) → `error`, no `done`.
- `start` pulsed during `SHIFT` with a different `data` value → ignored, and the original byte completes.
- Assert `reset` during `SHIFT` at bit 4 → both oe drop the same cycle, `busy`=0; a new `start` then completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length and parity helper.
// Used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQUEST   = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// 2-FF synchronizer for the PS/2 clock and data pins plus a falling-edge flag
// for each (previous synced value 1, current 0).
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall,
  output logic data_fall
);

  // bit 0 = PS/2 clock, bit 1 = PS/2 data; idle bus level is 1
  logic [1:0] meta, sync, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 2'b11;
      sync <= 2'b11;
      prev <= 2'b11;
    end else begin
      meta <= {data_in, clk_in};
      sync <= meta;
      prev <= sync;
    end
  end

  assign clk_s     = sync[0];
  assign data_s    = sync[1];
  assign clk_fall  = prev[0] & ~sync[0];
  assign data_fall = prev[1] & ~sync[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first,
// odd parity and stop, then device ACK check. Drives open-drain pull-low enables.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 25_000_000,
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic                      clk_s, data_s, clk_fall, unused_data_fall;
  logic [2:0]                state;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic [CW-1:0]             cnt;
  logic [3:0]                edge_cnt;
  logic                      ack_s;
  logic                      tmo;

  ps2_sync u_sync (
    .clk       (clk),
    .rst       (reset),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_s     (clk_s),
    .data_s    (data_s),
    .clk_fall  (clk_fall),
    .data_fall (unused_data_fall)
  );

  assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      frame       <= '1;
      cnt         <= '0;
      edge_cnt    <= '0;
      ack_s       <= 1'b1;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          // busy is still high in the done/error cycle, so a start there is dropped
          if (start && !busy) begin
            frame      <= {1'b1, odd_parity(data), data, 1'b0};
            cnt        <= '0;
            edge_cnt   <= '0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;
            state       <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= ~frame[0];
          cnt         <= '0;
          state       <= ST_SHIFT;
        end
        ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= 1'b1;
            state       <= ST_IDLE;
          end else if (state == ST_SHIFT) begin
            if (clk_fall) begin
              if (edge_cnt == 4'd10) begin
                // device drives ACK low before its 11th falling edge
                ps2_data_oe <= 1'b0;
                ack_s       <= data_s;
                state       <= ST_ACK;
              end else begin
                frame       <= {1'b1, frame[PS2_FRAME_BITS-1:1]};
                ps2_data_oe <= ~frame[1];
                edge_cnt    <= edge_cnt + 1'b1;
              end
            end
          end else if (state == ST_ACK) begin
            if (ack_s) begin
              error <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT_IDLE;
            end
          end else if (clk_s && data_s) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: table of transfers against a device BFM, random bytes,
// plus hand sequences for timeout and start-while-busy/reset corners.
module tb_ps2_tx;

  localparam int INH = 50;
  localparam int TMO = 5000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       bfm_clk = 1'b0;   // 1 = device pulls clock low
  logic       bfm_data = 1'b0;  // 1 = device pulls data low
  logic       pin_clk, pin_data;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, error;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;
  int cyc = 0;

  assign pin_clk  = ~(ps2_clk_oe | bfm_clk);
  assign pin_data = ~(ps2_data_oe | bfm_data);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data        (d_in),
    .ps2_clk_in  (pin_clk),
    .ps2_data_in (pin_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) n_done++;
    if (error) n_err++;
    if (done || error) begin
      total++;
      if (done && error) begin
        bad++;
        $display("FAIL done_error_exclusive: both high at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: odd parity bit is 1 when the byte holds an even number of ones
  function automatic int ref_parity(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1 : 0;
  endfunction

  typedef struct {
    logic [7:0] d;
    bit         ack;
    int         glitch;   // clock pulse at which a stray start is pulsed (0 = none)
    int         rst_at;   // clock pulse at which reset is asserted (0 = none)
    int         exp_done;
    int         exp_err;
  } vec_t;

  task automatic xfer(input vec_t v);
    logic [7:0] got = 8'h00;
    int par = -1, stp = -1, oe_cnt = 0, lowc, k, d0, e0;
    bit aborted = 1'b0;
    d0 = n_done;
    e0 = n_err;
    @(negedge clk);
    d_in = v.d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d_in = ~v.d;
    chk("busy_rise", busy, 1);
    chk("clk_oe_rise", ps2_clk_oe, 1);
    lowc = 1;
    while (ps2_clk_oe && lowc < 200) begin
      @(negedge clk);
      if (ps2_clk_oe) lowc++;
    end
    chk("clk_low_cycles", lowc, INH + 1);
    chk("start_bit", pin_data, 0);
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && v.ack) bfm_data = 1'b1;
      bfm_clk = 1'b1;
      repeat (10) @(negedge clk);
      if (i == v.glitch) begin
        start = 1'b1;
        d_in = ~v.d;
        @(negedge clk);
        start = 1'b0;
      end
      if (i == v.rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        bfm_clk = 1'b0;
        aborted = 1'b1;
        break;
      end
      repeat (30) @(negedge clk);
      bfm_clk = 1'b0;
      if (i <= 8) begin
        got[i-1] = pin_data;
        if (ps2_data_oe) oe_cnt++;
      end
      if (i == 9) par = pin_data;
      if (i == 10) stp = pin_data;
      bfm_data = 1'b0;
      if (i < 11) repeat (40) @(negedge clk);
    end
    bfm_data = 1'b0;
    k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_count", n_done - d0, v.exp_done);
    chk("error_count", n_err - e0, v.exp_err);
    if (!aborted) begin
      chk("data_byte", got, v.d);
      chk("parity", par, ref_parity(v.d));
      chk("stop", stp, 1);
      chk("data_oe_zero_bits", oe_cnt, 8 - $countones(v.d));
    end
  endtask

  vec_t tbl[8];

  initial begin
    int k, c0, d0, e0;
    vec_t rv;
    tbl[0] = '{8'hED, 1'b1, 0, 0, 1, 0};
    tbl[1] = '{8'h01, 1'b1, 0, 0, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 0, 0, 1, 0};
    tbl[3] = '{8'h00, 1'b1, 0, 0, 1, 0};
    tbl[4] = '{8'hA5, 1'b0, 0, 0, 0, 1};
    tbl[5] = '{8'h3C, 1'b1, 3, 0, 1, 0};
    tbl[6] = '{8'h96, 1'b1, 0, 4, 0, 0};
    tbl[7] = '{8'h5A, 1'b1, 0, 0, 1, 0};

    #1;
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_data_oe", ps2_data_oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    foreach (tbl[i]) xfer(tbl[i]);

    for (int i = 0; i < 5; i++) begin
      rv = '{8'($urandom), 1'b1, 0, 0, 1, 0};
      xfer(rv);
    end

    // device never clocks: error exactly TMO cycles after shift entry
    d0 = n_done;
    e0 = n_err;
    @(negedge clk);
    d_in = 8'h12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (ps2_clk_oe && k < 200) begin
      @(negedge clk);
      k++;
    end
    c0 = cyc;
    chk("tmo_start_bit", ps2_data_oe, 1);
    k = 0;
    while (!error && k < TMO + 500) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_cycles", cyc - c0, TMO);
    @(negedge clk);
    chk("tmo_clk_oe", ps2_clk_oe, 0);
    chk("tmo_data_oe", ps2_data_oe, 0);
    repeat (3) @(negedge clk);
    chk("tmo_busy", busy, 0);
    chk("tmo_error_count", n_err - e0, 1);
    chk("tmo_done_count", n_done - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
